cfu_mac_engine: RTL and testbench
=================================

// Module: cfu_mac_engine
// PURPOSE
//  Parametrised CFU datapath: LANES-wide SIMD int8 dot-product with per-operand offsets, persistent
//  accumulator, and output clamp. Sits on the CPU custom-function port; a fused command returns a
//  bias-added, clamped result and clears the accumulator. All commands use fixed latency.
// PARAMETERS
//  LANES   4   SIMD lanes per command; LANES*ELEM_W <= 32 (elaboration $error otherwise)
//  ELEM_W  8   signed element width per lane
//  OFF_W   16  offset register width; offsets sign-extended from OFF_W bits
//  ACC_W   32  accumulator width; wraps modulo 2^ACC_W, no saturation
// PORTS
//  clk                      in   1   clock
//  reset                    in   1   reset
//  cmd_valid                in   1   command offered
//  cmd_ready                out  1   command accepted when cmd_valid & cmd_ready
//  cmd_payload_function_id  in   10  [9:3]=opcode, [2:0] ignored
//  cmd_payload_inputs_0     in   32  operand A / lane data (lane i = bits [i*ELEM_W +: ELEM_W])
//  cmd_payload_inputs_1     in   32  operand B / lane data
//  rsp_valid                out  1   response held until rsp_ready
//  rsp_ready                in   1   CPU accepts response
//  rsp_payload_outputs_0    out  32  result, ACC_W sign-extended/truncated to 32
// BEHAVIOUR
//  Reset: reset, synchronous, active-high; clock clk. rsp_valid=0, rsp_payload_outputs_0=0, acc=0,
//   in_off=f_off=0, clamp_min=-2^31, clamp_max=2^31-1, state=IDLE. Reset wins over everything, incl.
//   mid-command (CALC/RESP): command dropped, no response issued.
//  FSM: IDLE -(cmd_valid)-> CALC -> RESP -(rsp_ready)-> IDLE. cmd_ready=1 only in IDLE.
//   Operands latched on acceptance (cycle T); rsp_valid rises at T+2; payload stable while rsp_valid.
//   rsp_ready sampled only in RESP; rsp_ready=1 at T+2 returns to IDLE at T+3. Throughput 1 cmd/3 clk.
//   cmd_valid in CALC/RESP not accepted; payload changes then are ignored.
//  Opcodes (function_id[9:3]):
//   0 SET_OFF : in_off=in0[OFF_W-1:0], f_off=in1[OFF_W-1:0]; acc=0; rsp=0
//   1 MAC     : acc += sum_i (A_i+in_off)*(B_i+f_off); rsp = updated acc
//   2 SET_CLMP: clamp_min=in0, clamp_max=in1; rsp=0
//   3 CLAMP   : rsp = clamp(in0); acc unchanged
//   4 DRAIN   : rsp = clamp(acc + in0 as bias); acc=0 in same update
//   5 CLEAR   : rsp = acc before clear; acc=0
//   other     : rsp=0, no state change
//  Arithmetic: lane operands sign-extended to OFF_W+1 before offset add; products 2*(OFF_W+1) bits;
//   lane sum in ACC_W; acc add wraps. Lanes with index >= LANES do not exist (upper input bits ignored).
//  Clamp (signed 32): v<min -> min; else v>max -> max; else v. If min>max result is always min.
//  acc state updates in CALC; products registered in CALC, result registered into payload on CALC->RESP.
// STRUCTURE
//  Package cfu_mac_pkg: opcode localparams (OP_SET_OFF..OP_CLEAR), FSM state enum, clamp function.
//  Sub-module cfu_mac_lanes: LANES-wide offset-add/multiply/adder-tree, inputs from cmd latches,
//   one output register (the CALC stage). Top holds FSM, offsets, clamp regs, accumulator.
// TESTING
//  Reset, SET_OFF(128,0), MAC A=0x01010101 B=0x02020202 -> rsp 1032 (4*129*2), rsp_valid at T+2
//  Second MAC A=0xFFFFFFFF(-1 lanes) B=0x01010101 -> rsp 1032+4*127=1540; SET_OFF clears -> next MAC fresh
//  SET_CLMP(-128,127); CLAMP in0=300 -> 127; in0=-500 -> -128; in0=5 -> 5; min>max(10,0) in0=5 -> 10
//  acc=1540, DRAIN in0=-1500 -> 40, following CLEAR -> 0; acc wrap: acc=0x7FFFFFF0 then +32 -> 0x80000010
//  Backpressure: rsp_ready low 5 cycles -> payload/rsp_valid stable, cmd_ready=0, second cmd not taken
//  Reset asserted in CALC -> no rsp_valid; acc=0, offsets=0, clamp at full range after; opcode 9 -> rsp 0

Source files
------------

// File: rtl/cfu_mac_pkg.sv
// cfu_mac_pkg: shared definitions for the CFU MAC engine.
//   - Opcode constants, decoded from function_id[9:3].
//   - FSM state encodings (IDLE -> CALC -> RESP), with a state_t alias.
//   - clamp32: signed 32-bit clamp. When min > max the result is always min.
package cfu_mac_pkg;

  localparam logic [6:0] OP_SET_OFF  = 7'd0;
  localparam logic [6:0] OP_MAC      = 7'd1;
  localparam logic [6:0] OP_SET_CLMP = 7'd2;
  localparam logic [6:0] OP_CLAMP    = 7'd3;
  localparam logic [6:0] OP_DRAIN    = 7'd4;
  localparam logic [6:0] OP_CLEAR    = 7'd5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // An inverted range (min > max) always yields min, whatever v is.
  function automatic logic [31:0] clamp32(input logic [31:0] v,
                                          input logic [31:0] mn,
                                          input logic [31:0] mx);
    if ($signed(mn) > $signed(mx))     return mn;
    else if ($signed(v) < $signed(mn)) return mn;
    else if ($signed(v) > $signed(mx)) return mx;
    else                               return v;
  endfunction

endpackage

// File: rtl/cfu_mac_lanes.sv
// cfu_mac_lanes: LANES-wide signed dot product with per-operand offsets.
// Each lane computes (A_i + in_off) * (B_i + f_off). Elements and offsets are
// sign-extended to OFF_W+1 bits, and each product is 2*(OFF_W+1) bits. The
// lane products are summed modulo 2^ACC_W into one output register.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   load_i           capture a new sum (asserted on command acceptance)
//   a_i, b_i         packed lane data; lane i = [i*ELEM_W +: ELEM_W]
//   in_off_i         offset added to every A lane
//   f_off_i          offset added to every B lane
//   sum_o            registered lane sum
module cfu_mac_lanes
  import cfu_mac_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int ELEM_W = 8,
  parameter int OFF_W  = 16,
  parameter int ACC_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [31:0]      a_i,
  input  logic [31:0]      b_i,
  input  logic [OFF_W-1:0] in_off_i,
  input  logic [OFF_W-1:0] f_off_i,
  output logic [ACC_W-1:0] sum_o
);

  localparam int PROD_W = 2 * (OFF_W + 1);

  if (LANES * ELEM_W > 32) begin : g_width_check
    $error("cfu_mac_lanes: LANES*ELEM_W must not exceed 32");
  end

  logic signed [OFF_W-1:0]  in_off_s;
  logic signed [OFF_W-1:0]  f_off_s;
  logic signed [PROD_W-1:0] prods [LANES];
  logic [ACC_W-1:0]         sum_d;
  logic [ACC_W-1:0]         sum_q;

  assign in_off_s = in_off_i;
  assign f_off_s  = f_off_i;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [ELEM_W-1:0] a_e;
    logic signed [ELEM_W-1:0] b_e;
    logic signed [OFF_W:0]    a_x;
    logic signed [OFF_W:0]    b_x;

    assign a_e = a_i[g*ELEM_W +: ELEM_W];
    assign b_e = b_i[g*ELEM_W +: ELEM_W];
    // Size casts on signed operands sign-extend before the offset add.
    assign a_x = (OFF_W+1)'(a_e) + (OFF_W+1)'(in_off_s);
    assign b_x = (OFF_W+1)'(b_e) + (OFF_W+1)'(f_off_s);
    assign prods[g] = PROD_W'(a_x) * PROD_W'(b_x);
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d + ACC_W'(prods[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else if (load_i) begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/cfu_mac_engine.sv
// cfu_mac_engine: CFU datapath for a SIMD int8 dot product with offsets,
// a persistent accumulator and a clamp on the output.
// Handshake: a command transfers on a cycle where cmd_valid & cmd_ready
// (cmd_ready is high only in IDLE). The response holds rsp_valid and the
// payload steady until a cycle with rsp_valid & rsp_ready. Latency is fixed:
// acceptance at cycle T, rsp_valid at T+2, and back in IDLE at T+3 when
// rsp_ready is high at T+2.
// Ports:
//   clk, reset                clock and synchronous active-high reset
//   cmd_valid / cmd_ready     command handshake
//   cmd_payload_function_id   [9:3] opcode, [2:0] ignored
//   cmd_payload_inputs_0/1    operands / packed lane data
//   rsp_valid / rsp_ready     response handshake
//   rsp_payload_outputs_0     32-bit result
//   dbg_state_o               current FSM state (ST_IDLE/ST_CALC/ST_RESP)
module cfu_mac_engine
  import cfu_mac_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int ELEM_W = 8,
  parameter int OFF_W  = 16,
  parameter int ACC_W  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output logic [1:0]  dbg_state_o
);

  state_t           state_q, state_d;
  logic [6:0]       op_q;
  logic [31:0]      in0_q, in1_q;
  logic [OFF_W-1:0] in_off_q, in_off_d;
  logic [OFF_W-1:0] f_off_q, f_off_d;
  logic [31:0]      cmin_q, cmin_d;
  logic [31:0]      cmax_q, cmax_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [31:0]      rsp_q, rsp_d;
  logic [ACC_W-1:0] lane_sum;
  logic [ACC_W-1:0] acc_mac;
  logic [ACC_W-1:0] acc_bias;
  logic             accept;
  logic             unused_fid_bits;

  assign unused_fid_bits = ^cmd_payload_function_id[2:0];

  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign accept      = cmd_valid & cmd_ready;
  assign dbg_state_o = state_q;
  assign rsp_payload_outputs_0 = rsp_q;

  // The lane register loads together with the operand latches, so the CALC
  // cycle already holds the dot product.
  cfu_mac_lanes #(
    .LANES  (LANES),
    .ELEM_W (ELEM_W),
    .OFF_W  (OFF_W),
    .ACC_W  (ACC_W)
  ) u_lanes (
    .clk      (clk),
    .reset    (reset),
    .load_i   (accept),
    .a_i      (cmd_payload_inputs_0),
    .b_i      (cmd_payload_inputs_1),
    .in_off_i (in_off_q),
    .f_off_i  (f_off_q),
    .sum_o    (lane_sum)
  );

  // The accumulator wraps modulo 2^ACC_W. The DRAIN bias is sign-extended.
  assign acc_mac  = acc_q + lane_sum;
  assign acc_bias = acc_q + ACC_W'($signed(in0_q));

  always_comb begin
    state_d  = state_q;
    in_off_d = in_off_q;
    f_off_d  = f_off_q;
    cmin_d   = cmin_q;
    cmax_d   = cmax_q;
    acc_d    = acc_q;
    rsp_d    = rsp_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_CALC;
      ST_CALC: begin
        state_d = ST_RESP;
        rsp_d   = '0;
        case (op_q)
          OP_SET_OFF: begin
            in_off_d = in0_q[OFF_W-1:0];
            f_off_d  = in1_q[OFF_W-1:0];
            acc_d    = '0;
          end
          OP_MAC: begin
            acc_d = acc_mac;
            rsp_d = 32'($signed(acc_mac));
          end
          OP_SET_CLMP: begin
            cmin_d = in0_q;
            cmax_d = in1_q;
          end
          OP_CLAMP: rsp_d = clamp32(in0_q, cmin_q, cmax_q);
          OP_DRAIN: begin
            rsp_d = clamp32(32'($signed(acc_bias)), cmin_q, cmax_q);
            acc_d = '0;
          end
          OP_CLEAR: begin
            rsp_d = 32'($signed(acc_q));
            acc_d = '0;
          end
          default: ;
        endcase
      end
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      in0_q    <= '0;
      in1_q    <= '0;
      in_off_q <= '0;
      f_off_q  <= '0;
      cmin_q   <= 32'h8000_0000;
      cmax_q   <= 32'h7FFF_FFFF;
      acc_q    <= '0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      in_off_q <= in_off_d;
      f_off_q  <= f_off_d;
      cmin_q   <= cmin_d;
      cmax_q   <= cmax_d;
      acc_q    <= acc_d;
      rsp_q    <= rsp_d;
      if (accept) begin
        op_q  <= cmd_payload_function_id[9:3];
        in0_q <= cmd_payload_inputs_0;
        in1_q <= cmd_payload_inputs_1;
      end
    end
  end

endmodule

// File: tb/tb_cfu_mac_engine.sv
module tb_cfu_mac_engine;

  localparam logic [6:0] T_SET_OFF = 7'd0;
  localparam logic [6:0] T_MAC     = 7'd1;
  localparam logic [6:0] T_SETCLMP = 7'd2;
  localparam logic [6:0] T_CLAMP   = 7'd3;
  localparam logic [6:0] T_DRAIN   = 7'd4;
  localparam logic [6:0] T_CLEAR   = 7'd5;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  fid;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  // Reference model state: plain integers.
  int m_acc, m_in_off, m_f_off, m_cmin, m_cmax;

  cfu_mac_engine dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (fid),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_data),
    .dbg_state_o             (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model_reset();
    m_acc = 0; m_in_off = 0; m_f_off = 0;
    m_cmin = -2147483647 - 1;
    m_cmax = 2147483647;
  endfunction

  function automatic int model_clamp(int v);
    if (m_cmin > m_cmax) return m_cmin;
    if (v < m_cmin) return m_cmin;
    if (v > m_cmax) return m_cmax;
    return v;
  endfunction

  function automatic logic [31:0] model_exec(logic [6:0] op, logic [31:0] a, logic [31:0] b);
    longint s;
    int ea, eb;
    logic [31:0] r;
    r = '0;
    case (op)
      T_SET_OFF: begin
        m_in_off = int'($signed(a[15:0]));
        m_f_off  = int'($signed(b[15:0]));
        m_acc    = 0;
      end
      T_MAC: begin
        s = 0;
        for (int i = 0; i < 4; i++) begin
          ea = int'($signed(a[8*i +: 8]));
          eb = int'($signed(b[8*i +: 8]));
          s += longint'(ea + m_in_off) * longint'(eb + m_f_off);
        end
        m_acc = int'(longint'(m_acc) + s);
        r = m_acc;
      end
      T_SETCLMP: begin
        m_cmin = $signed(a);
        m_cmax = $signed(b);
      end
      T_CLAMP: r = model_clamp($signed(a));
      T_DRAIN: begin
        r = model_clamp(int'(longint'(m_acc) + longint'($signed(a))));
        m_acc = 0;
      end
      T_CLEAR: begin
        r = m_acc;
        m_acc = 0;
      end
      default: ;
    endcase
    return r;
  endfunction

  // ---------------- driver ----------------
  // One complete command with rsp_ready high at T+2; ok reports whether the
  // handshake timing looked right (ready at offer, valid only at T+2).
  task automatic do_cmd(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rsp, output bit ok);
    ok = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1;
    fid = {op, 3'($urandom_range(0, 7))};
    in0 = a;
    in1 = b;
    if (cmd_ready !== 1'b1) ok = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    fid = 10'($urandom);
    in0 = $urandom;
    in1 = $urandom;
    if (rsp_valid !== 1'b0) ok = 1'b0;
    @(negedge clk);
    if (rsp_valid !== 1'b1) ok = 1'b0;
    rsp = rsp_data;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) ok = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid);
    end
    checks++;
    if (rsp_data !== 32'd0) begin
      errors++; $display("FAIL reset_payload got %h want 0", rsp_data);
    end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_mac_offsets();
    logic [6:0]  ops[5] = '{T_SET_OFF, T_MAC, T_MAC, T_SET_OFF, T_MAC};
    logic [31:0] as[5]  = '{32'd128, 32'h01010101, 32'hFFFFFFFF, 32'd0, 32'h01010101};
    logic [31:0] bs[5]  = '{32'd0, 32'h02020202, 32'h01010101, 32'd0, 32'h01010101};
    logic [31:0] ex[5]  = '{32'd0, 32'd1032, 32'd1540, 32'd0, 32'd4};
    logic [31:0] rsp;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      do_cmd(ops[i], as[i], bs[i], rsp, ok);
      void'(model_exec(ops[i], as[i], bs[i]));
      checks++;
      if (rsp !== ex[i]) begin
        errors++; $display("FAIL mac_offsets[%0d] got %0d want %0d", i, rsp, ex[i]);
      end
      checks++;
      if (!ok) begin
        errors++; $display("FAIL mac_offsets_timing[%0d] got bad handshake want T+2 response", i);
      end
    end
  endtask

  task automatic test_clamp();
    logic [6:0]  ops[8] = '{T_SETCLMP, T_CLAMP, T_CLAMP, T_CLAMP, T_SETCLMP, T_CLAMP,
                            T_SETCLMP, T_CLAMP};
    logic [31:0] as[8]  = '{32'hFFFFFF80, 32'd300, 32'hFFFFFE0C, 32'd5, 32'd10, 32'd5,
                            32'h80000000, 32'h80000000};
    logic [31:0] bs[8]  = '{32'd127, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h7FFFFFFF, 32'd0};
    logic [31:0] ex[8]  = '{32'd0, 32'd127, 32'hFFFFFF80, 32'd5, 32'd0, 32'd10,
                            32'd0, 32'h80000000};
    logic [31:0] rsp;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      do_cmd(ops[i], as[i], bs[i], rsp, ok);
      void'(model_exec(ops[i], as[i], bs[i]));
      checks++;
      if (rsp !== ex[i] || !ok) begin
        errors++; $display("FAIL clamp[%0d] got %h ok=%0b want %h", i, rsp, ok, ex[i]);
      end
    end
  endtask

  task automatic test_drain_clear();
    logic [6:0]  ops[8] = '{T_SETCLMP, T_SET_OFF, T_MAC, T_MAC, T_DRAIN, T_CLEAR, T_DRAIN, T_CLEAR};
    logic [31:0] as[8]  = '{32'hFFFFFF80, 32'd128, 32'h01010101, 32'hFFFFFFFF,
                            32'hFFFFFA24, 32'd0, 32'd1000, 32'd0};
    logic [31:0] bs[8]  = '{32'd127, 32'd0, 32'h02020202, 32'h01010101, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] ex[8]  = '{32'd0, 32'd0, 32'd1032, 32'd1540, 32'd40, 32'd0, 32'd127, 32'd0};
    logic [31:0] rsp;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      do_cmd(ops[i], as[i], bs[i], rsp, ok);
      void'(model_exec(ops[i], as[i], bs[i]));
      checks++;
      if (rsp !== ex[i] || !ok) begin
        errors++; $display("FAIL drain_clear[%0d] got %0d ok=%0b want %0d", i, rsp, ok, ex[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [6:0]  ops[9] = '{T_SETCLMP, T_SET_OFF, T_MAC, T_MAC, T_DRAIN, T_MAC, T_MAC, T_MAC, T_MAC};
    logic [31:0] as[9]  = '{32'h80000000, 32'h4000, 32'd0, 32'h4, 32'd32, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] bs[9]  = '{32'h7FFFFFFF, 32'h4000, 32'd0, 32'hFC, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] ex[9]  = '{32'd0, 32'd0, 32'h40000000, 32'h7FFFFFF0, 32'h80000010,
                            32'h40000000, 32'h80000000, 32'hC0000000, 32'h00000000};
    logic [31:0] rsp;
    bit ok;
    for (int i = 0; i < 9; i++) begin
      do_cmd(ops[i], as[i], bs[i], rsp, ok);
      void'(model_exec(ops[i], as[i], bs[i]));
      checks++;
      if (rsp !== ex[i] || !ok) begin
        errors++; $display("FAIL wrap[%0d] got %h ok=%0b want %h", i, rsp, ok, ex[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_mac, exp_clr, held, rsp;
    bit ok;
    do_cmd(T_SET_OFF, 32'd0, 32'd0, rsp, ok);
    void'(model_exec(T_SET_OFF, 32'd0, 32'd0));
    exp_mac = model_exec(T_MAC, 32'h01020304, 32'h05060708);
    @(negedge clk);
    cmd_valid = 1'b1; fid = {T_MAC, 3'd0}; in0 = 32'h01020304; in1 = 32'h05060708;
    @(negedge clk);
    // A SET_OFF stays offered through CALC and RESP; it must never be taken.
    fid = {T_SET_OFF, 3'd0}; in0 = 32'd77; in1 = 32'd99;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_early_valid got %b want 0", rsp_valid);
    end
    @(negedge clk);
    held = rsp_data;
    checks++;
    if (rsp_valid !== 1'b1 || held !== exp_mac) begin
      errors++; $display("FAIL bp_first got valid=%b data=%0d want 1/%0d", rsp_valid, held, exp_mac);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got valid=%b data=%h ready=%b want 1/%h/0",
                 c, rsp_valid, rsp_data, cmd_ready, held);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", rsp_valid, cmd_ready);
    end
    exp_clr = model_exec(T_CLEAR, 32'd0, 32'd0);
    do_cmd(T_CLEAR, 32'd0, 32'd0, rsp, ok);
    checks++;
    if (rsp !== exp_clr || !ok) begin
      errors++; $display("FAIL bp_not_taken got %0d ok=%0b want %0d", rsp, ok, exp_clr);
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0]  ops[7] = '{T_CLEAR, T_CLAMP, T_CLAMP, T_MAC, 7'd9, T_CLEAR, T_CLEAR};
    logic [31:0] as[7]  = '{32'd0, 32'h80000000, 32'h7FFFFFFF, 32'h01010101, 32'h12345678, 32'd0, 32'd0};
    logic [31:0] bs[7]  = '{32'd0, 32'd0, 32'd0, 32'h01010101, 32'h9ABCDEF0, 32'd0, 32'd0};
    logic [31:0] ex[7]  = '{32'd0, 32'h80000000, 32'h7FFFFFFF, 32'd4, 32'd0, 32'd4, 32'd0};
    logic [31:0] rsp;
    bit ok;
    do_cmd(T_SET_OFF, 32'd5, 32'd7, rsp, ok);
    void'(model_exec(T_SET_OFF, 32'd5, 32'd7));
    do_cmd(T_SETCLMP, 32'hFFFFFFF6, 32'd10, rsp, ok);
    void'(model_exec(T_SETCLMP, 32'hFFFFFFF6, 32'd10));
    do_cmd(T_MAC, 32'h01010101, 32'h01010101, rsp, ok);
    checks++;
    if (rsp !== model_exec(T_MAC, 32'h01010101, 32'h01010101) || !ok) begin
      errors++; $display("FAIL rmid_pre_mac got %0d ok=%0b want 192", rsp, ok);
    end
    @(negedge clk);
    cmd_valid = 1'b1; fid = {T_MAC, 3'd0}; in0 = 32'h01010101; in1 = 32'h01010101;
    @(negedge clk);
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL rmid_no_rsp[%0d] got %b want 0", c, rsp_valid);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 7; i++) begin
      do_cmd(ops[i], as[i], bs[i], rsp, ok);
      void'(model_exec(ops[i], as[i], bs[i]));
      checks++;
      if (rsp !== ex[i] || !ok) begin
        errors++; $display("FAIL rmid_after[%0d] got %h ok=%0b want %h", i, rsp, ok, ex[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0]  op;
    logic [31:0] a, b, rsp, exp;
    bit ok;
    for (int n = 0; n < 80; n++) begin
      op = 7'($urandom_range(0, 7));
      if (op > 7'd5) op = 7'($urandom_range(6, 127));
      a = $urandom;
      b = $urandom;
      exp_q.push_back(model_exec(op, a, b));
      do_cmd(op, a, b, rsp, ok);
      exp = exp_q.pop_front();
      checks++;
      if (rsp !== exp || !ok) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got %h ok=%0b want %h", n, op, a, b, rsp, ok, exp);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    fid = '0;
    in0 = '0;
    in1 = '0;
    rsp_ready = 1'b0;
    model_reset();
    test_reset();
    test_mac_offsets();
    test_clamp();
    test_drain_clear();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
